// File: rtl/serial_word_collector.sv
// serial_word_collector: MSB-first serial-to-parallel word collector with valid/ready output; even parity check when PARITY_EN is defined
module serial_word_collector #(
  parameter int WIDTH = 7,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             sin_first,
  output logic             sin_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, word_q, word_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, acc;
  assign sin_ready = state_q != HOLD;
  assign acc = sin_valid && sin_ready;
  assign shifted = {shreg_q[WIDTH-2:0], sin_bit};
  assign word_out = word_q;
  assign word_valid = valid_q;
  assign busy = state_q == SHIFT || state_q == PARITY;
  assign frame_err = fe_q;
  assign parity_err = pe_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    idle_d = idle_q;
    word_d = word_q;
    valid_d = valid_q;
    fe_d = 1'b0;
    pe_d = 1'b0;
    if (state_q == HOLD) begin
      if (valid_q && word_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end else if (acc && sin_first) begin
      fe_d = state_q != IDLE;
      shreg_d = WIDTH'(sin_bit);
      cnt_d = CW'(1);
      idle_d = '0;
      state_d = SHIFT;
    end else if (acc && state_q == IDLE) begin
      fe_d = 1'b1;
    end else if (acc && state_q == SHIFT) begin
      idle_d = '0;
      shreg_d = shifted;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
        state_d = PARITY;
`else
        word_d = shifted;
        valid_d = 1'b1;
        state_d = HOLD;
`endif
      end
`ifdef PARITY_EN
    end else if (acc) begin
      idle_d = '0;
      if (^{shreg_q, sin_bit}) begin
        pe_d = 1'b1;
        shreg_d = '0;
        cnt_d = '0;
        state_d = IDLE;
      end else begin
        word_d = shreg_q;
        valid_d = 1'b1;
        state_d = HOLD;
      end
`endif
    end else if (state_q != IDLE) begin
      idle_d = (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
      if (idle_q == IW'(TIMEOUT - 1)) begin
        fe_d = 1'b1;
        shreg_d = '0;
        cnt_d = '0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q <= '0;
      idle_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
      fe_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      idle_q <= idle_d;
      word_q <= word_d;
      valid_q <= valid_d;
      fe_q <= fe_d;
      pe_q <= pe_d;
    end
  end
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: directed stimulus with an expected-word queue checked by an independent monitor
module tb_serial_word_collector;
  logic clk = 1'b0;
  logic rst, sin_valid, sin_bit, sin_first, sin_ready, word_valid, word_ready, busy, frame_err, parity_err;
  logic [6:0] word_out;
  logic [6:0] exp_q[$];
  int vec = 0;
  int err = 0;
  int fe_cnt = 0;
  int fe0;
  serial_word_collector dut (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit), .sin_first(sin_first),
    .sin_ready(sin_ready), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && frame_err) fe_cnt++;
    if (!rst && word_valid && word_ready) begin
      vec++;
      if (exp_q.size() == 0) begin
        err++;
        $display("FAIL word_unexpected: got %b expected none", word_out);
      end else if (word_out !== exp_q[0]) begin
        err++;
        $display("FAIL word_data: got %b expected %b", word_out, exp_q.pop_front());
      end else void'(exp_q.pop_front());
    end
  end
  task automatic send(input logic b, input logic f);
    sin_valid = 1'b1;
    sin_bit = b;
    sin_first = f;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_first = 1'b0;
  endtask
  task automatic send_word(input logic [6:0] w);
    for (int i = 6; i >= 0; i--) send(w[i], i == 6);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    sin_valid = 1'b0;
    sin_bit = 1'b0;
    sin_first = 1'b0;
    word_ready = 1'b1;
    idle(3);
    chk("rst_word_out", word_out, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sin_ready", sin_ready, 1);
    chk("rst_errs", {frame_err, parity_err}, 0);
    rst = 1'b0;
    idle(1);
    exp_q.push_back(7'b0100110);
    send_word(7'b0100110);
    chk("t1_valid", word_valid, 1);
    chk("t1_sin_ready", sin_ready, 0);
    idle(1);
    chk("t1_valid_drop", word_valid, 0);
    chk("t1_word_kept", word_out, 7'b0100110);
    word_ready = 1'b0;
    exp_q.push_back(7'b1110001);
    send_word(7'b1110001);
    fe0 = fe_cnt;
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("t2_valid_held", word_valid, 1);
    chk("t2_word_held", word_out, 7'b1110001);
    chk("t2_sin_ready", sin_ready, 0);
    chk("t2_no_fe", fe_cnt, fe0);
    word_ready = 1'b1;
    idle(1);
    chk("t2_valid_drop", word_valid, 0);
    fe0 = fe_cnt;
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    exp_q.push_back(7'b0000000);
    send_word(7'b0000000);
    idle(2);
    chk("t3_fe_once", fe_cnt, fe0 + 1);
    chk("t3_word", word_out, 7'b0000000);
    fe0 = fe_cnt;
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    idle(14);
    chk("t4_busy_before_to", busy, 1);
    chk("t4_no_fe_yet", fe_cnt, fe0);
    idle(1);
    chk("t4_fe", frame_err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", word_valid, 0);
    send(1'b1, 1'b0);
    chk("stray_fe", frame_err, 1);
    chk("stray_busy", busy, 0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", word_valid, 0);
    chk("t5_word_clr", word_out, 0);
    exp_q.push_back(7'b1010101);
    send_word(7'b1010101);
    chk("t5_valid_after", word_valid, 1);
    idle(2);
`ifdef PARITY_EN
    exp_q.push_back(7'b0100110);
    send_word(7'b0100110);
    send(1'b1, 1'b0);
    chk("t6_par_ok_valid", word_valid, 1);
    idle(2);
    send_word(7'b0100110);
    send(1'b0, 1'b0);
    chk("t6_par_err", parity_err, 1);
    chk("t6_par_no_valid", word_valid, 0);
    idle(2);
`else
    chk("no_par_err", parity_err, 0);
`endif
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
